// File: rtl/alu_ctrl_seq.sv
// Execute-stage sequencer for the 64-bit ALU: decodes one op per handshake and synthesises SLT/SLTU.
// SLT/SLTU use a SUB pass plus a sign-fix cycle. Define ALU_CTRL_PERF_EN to add the perf_count_o handshake counter.
module alu_ctrl_seq #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        aluop_i,
  input  logic [2:0]        funct3_i,
  input  logic              funct7b5_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  output logic [CTRL_W-1:0] ctrl_signal_o,
  output logic [XLEN-1:0]   op1_o,
  output logic [XLEN-1:0]   op2_o,
  input  logic [XLEN-1:0]   alu_result_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [XLEN-1:0]   result_o,
  output logic              illegal_o
`ifdef ALU_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_count_o
`endif
);

  localparam logic [CTRL_W-1:0] CTRL_AND = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] CTRL_OR  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] CTRL_ADD = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] CTRL_SUB = CTRL_W'(4'b0110);

  typedef enum logic [1:0] {IDLE, EXEC, FIX, DONE} state_t;
  typedef enum logic [1:0] {K_PLAIN, K_SLT, K_SLTU, K_ILL} kind_t;

  state_t            state_q, state_d;
  kind_t             kind_q, dec_kind;
  logic [CTRL_W-1:0] ctrl_q, dec_ctrl;
  logic [XLEN-1:0]   op1_q, op2_q, result_q;
  logic              illegal_q;
  logic              sign_differs, fix_bit;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    dec_ctrl = CTRL_ADD;
    dec_kind = K_PLAIN;
    case (aluop_i)
      2'b00: dec_ctrl = CTRL_ADD;
      2'b01: dec_ctrl = CTRL_SUB;
      2'b10: begin
        case (funct3_i)
          3'b000: dec_ctrl = funct7b5_i ? CTRL_SUB : CTRL_ADD;
          3'b111: dec_ctrl = CTRL_AND;
          3'b110: dec_ctrl = CTRL_OR;
          3'b010: begin dec_ctrl = CTRL_SUB; dec_kind = K_SLT;  end
          3'b011: begin dec_ctrl = CTRL_SUB; dec_kind = K_SLTU; end
          default: dec_kind = K_ILL;
        endcase
      end
      default: dec_kind = K_ILL;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid_i) state_d = EXEC;
      EXEC: state_d = (kind_q == K_SLT || kind_q == K_SLTU) ? FIX : DONE;
      FIX:  state_d = DONE;
      DONE: if (res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // When operand signs differ the subtraction may overflow, so the answer follows from the signs alone.
  assign sign_differs = op1_q[XLEN-1] ^ op2_q[XLEN-1];
  always_comb begin
    fix_bit = result_q[XLEN-1];
    if (sign_differs) fix_bit = (kind_q == K_SLT) ? op1_q[XLEN-1] : op2_q[XLEN-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      kind_q    <= K_PLAIN;
      ctrl_q    <= CTRL_AND;
      op1_q     <= '0;
      op2_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            op1_q  <= rs1_i;
            op2_q  <= rs2_i;
            ctrl_q <= dec_ctrl;
            kind_q <= dec_kind;
          end
        end
        EXEC: begin
          result_q  <= (kind_q == K_ILL) ? '0 : alu_result_i;
          illegal_q <= (kind_q == K_ILL);
        end
        FIX: result_q <= {{(XLEN-1){1'b0}}, fix_bit};
        default: ;
      endcase
    end
  end

`ifdef ALU_CTRL_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) perf_q <= '0;
    else if (state_q == DONE && res_ready_i) perf_q <= perf_q + 32'd1;
  end
  assign perf_count_o = perf_q;
`endif

  assign in_ready_o    = (state_q == IDLE);
  assign res_valid_o   = (state_q == DONE);
  assign ctrl_signal_o = ctrl_q;
  assign op1_o         = op1_q;
  assign op2_o         = op2_q;
  assign result_o      = result_q;
  assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: driver pushes reference-model results, a monitor pops and compares.
// The ALU itself is modelled here as a combinational function of the control code.
module tb_alu_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  aluop = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7b5 = 1'b0;
  logic [63:0] rs1 = '0, rs2 = '0;
  logic [3:0]  ctrl;
  logic [63:0] op1, op2, alu_result;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] result;
  logic        illegal;
`ifdef ALU_CTRL_PERF_EN
  logic [31:0] perf_count;
`endif

  alu_ctrl_seq #(.XLEN(64), .CTRL_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .aluop_i(aluop), .funct3_i(funct3), .funct7b5_i(funct7b5),
    .rs1_i(rs1), .rs2_i(rs2), .ctrl_signal_o(ctrl), .op1_o(op1), .op2_o(op2),
    .alu_result_i(alu_result), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .result_o(result), .illegal_o(illegal)
`ifdef ALU_CTRL_PERF_EN
    , .perf_count_o(perf_count)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    case (ctrl)
      4'b0000: alu_result = op1 & op2;
      4'b0001: alu_result = op1 | op2;
      4'b0010: alu_result = op1 + op2;
      4'b0110: alu_result = op1 - op2;
      default: alu_result = 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  end

  typedef struct {
    logic [63:0] res;
    logic        ill;
    logic [3:0]  ctrl;
    int          lat;
    int          accept_cyc;
    int          stall;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   hs_done = 0;
  int   hs_pend = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: results from the instruction semantics, not from the sequencer's internals.
  task automatic model(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic [63:0] a, input logic [63:0] b, output exp_t e);
    e.res = '0; e.ill = 1'b0; e.ctrl = 4'b0010; e.lat = 2; e.stall = 0; e.accept_cyc = 0;
    if (op == 2'b00)      e.res = a + b;
    else if (op == 2'b01) begin e.res = a - b; e.ctrl = 4'b0110; end
    else if (op == 2'b10 && f3 == 3'b000) begin
      e.res  = f7 ? a - b : a + b;
      e.ctrl = f7 ? 4'b0110 : 4'b0010;
    end
    else if (op == 2'b10 && f3 == 3'b111) begin e.res = a & b; e.ctrl = 4'b0000; end
    else if (op == 2'b10 && f3 == 3'b110) begin e.res = a | b; e.ctrl = 4'b0001; end
    else if (op == 2'b10 && f3 == 3'b010) begin
      e.res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0; e.ctrl = 4'b0110; e.lat = 3;
    end
    else if (op == 2'b10 && f3 == 3'b011) begin
      e.res = (a < b) ? 64'd1 : 64'd0; e.ctrl = 4'b0110; e.lat = 3;
    end
    else e.ill = 1'b1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                      input logic [63:0] a, input logic [63:0] b, input int stall);
    exp_t e;
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    if (!in_ready) begin
      n_vec++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", w);
      return;
    end
    aluop = op; funct3 = f3; funct7b5 = f7; rs1 = a; rs2 = b; in_valid = 1'b1;
    model(op, f3, f7, a, b, e);
    e.accept_cyc = cyc + 1;
    e.stall = stall;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
  endtask

  exp_t        cur;
  bit          busy = 1'b0;
  int          waited = 0;
  logic [63:0] first_res;
  logic        first_ill;

  always @(negedge clk) begin
    if (mon_en) begin
      hs_done += hs_pend;
      hs_pend = 0;
      if (res_valid) begin
        if (!busy) begin
          if (q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL unexpected_result: result %h with empty scoreboard", result);
          end else begin
            cur = q.pop_front();
            busy = 1'b1;
            waited = 0;
            first_res = result;
            first_ill = illegal;
            check("latency", 64'(cyc + 1 - cur.accept_cyc), 64'(cur.lat));
            check("result", result, cur.res);
            check("illegal", 64'(illegal), 64'(cur.ill));
            check("ctrl", 64'(ctrl), 64'(cur.ctrl));
`ifdef ALU_CTRL_PERF_EN
            check("perf_count", 64'(perf_count), 64'(hs_done));
`endif
          end
        end else begin
          check("result_hold", result, first_res);
          check("illegal_hold", 64'(illegal), 64'(first_ill));
        end
        check("in_ready_while_done", 64'(in_ready), 64'd0);
        if (busy && waited >= cur.stall) begin
          res_ready = 1'b1;
          busy = 1'b0;
          hs_pend = 1;
        end else begin
          res_ready = 1'b0;
          waited++;
        end
      end else begin
        res_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    logic [63:0] a, b;
    int w;
    // Power-up reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    rst = 1'b0;

    // Reset in the middle of an SLT: the op must vanish
    @(negedge clk);
    aluop = 2'b10; funct3 = 3'b010; rs1 = 64'h8000_0000_0000_0000; rs2 = 64'd1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midop_rst_in_ready", 64'(in_ready), 64'd1);
    check("midop_rst_res_valid", 64'(res_valid), 64'd0);
    check("midop_rst_result", result, 64'd0);
    check("midop_rst_illegal", 64'(illegal), 64'd0);
    check("midop_rst_ctrl", 64'(ctrl), 64'd0);
    check("midop_rst_op1", op1, 64'd0);
    check("midop_rst_op2", op2, 64'd0);
`ifdef ALU_CTRL_PERF_EN
    check("midop_rst_perf", 64'(perf_count), 64'd0);
`endif
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("discarded_no_valid", 64'(res_valid), 64'd0);
    end

    mon_en = 1'b1;
    send(2'b10, 3'b000, 1'b1, 64'd5, 64'd7, 0);
    send(2'b10, 3'b010, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 0);
    send(2'b10, 3'b011, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 0);
    send(2'b10, 3'b010, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    send(2'b10, 3'b011, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    send(2'b10, 3'b111, 1'b0, 64'hF0, 64'h3C, 0);
    send(2'b10, 3'b110, 1'b0, 64'hF0, 64'h3C, 0);
    send(2'b00, 3'b101, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0);
    send(2'b01, 3'b000, 1'b0, 64'd3, 64'd9, 5);
    send(2'b11, 3'b000, 1'b0, 64'd1, 64'd1, 0);
    send(2'b10, 3'b001, 1'b0, 64'd4, 64'd4, 2);
    send(2'b10, 3'b010, 1'b0, 64'd9, 64'd9, 0);

    for (int i = 0; i < 200; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a[63] = ~a[63];
      if ($urandom_range(0, 3) == 0) b = a;
      send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           a, b, $urandom_range(0, 3));
    end

    w = 0;
    while ((q.size() != 0 || busy) && w < 200) begin @(negedge clk); w++; end
    if (q.size() != 0 || busy) begin
      n_vec++; n_fail++;
      $display("FAIL drain_timeout: %0d results still outstanding", q.size());
    end
    repeat (2) @(negedge clk);
`ifdef ALU_CTRL_PERF_EN
    check("perf_count_final", 64'(perf_count), 64'(hs_done));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
